addr8s_tr_checker: RTL and testbench

- Sequential front/back-end stage wrapped around an 8-bit signed, fault-resilient combinational adder.
- Accepts operand pairs over a valid/ready handshake and drives the adder inputs, then samples its 9-bit sum.
- Uses temporal redundancy: pass 1 evaluates A+B, pass 2 evaluates B+A with swapped operands so different gate paths are exercised.
- Compares the two passes, emits the sum with an error flag, and keeps a saturating mismatch counter.

---
 rtl/addr8s_tr_checker_if.sv | 22 ++
 rtl/addr8s_tr_checker.sv | 167 ++++++++++++++++
 tb/tb_addr8s_tr_checker.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/addr8s_tr_checker_if.sv
// Operand/result handshake bundle for addr8s_tr_checker.
// The slave modport is the checker's view; the master modport drives pairs and takes results.
interface addr8s_tr_checker_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_sum;
    logic       out_err;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_err
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_err
    );
endinterface

// File: rtl/addr8s_tr_checker.sv
// Temporal-redundancy checker around an external 8-bit signed adder (A+B, then B+A).
// Define ADDR8S_TR_VOTE_EN to add a third A+B pass that votes between disagreeing results.
module addr8s_tr_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    addr8s_tr_checker_if.slave   bus,
    output logic [7:0]           add_a,
    output logic [7:0]           add_b,
    input  logic [8:0]           add_sum,
    input  logic                 err_clr,
    output logic [ERR_W-1:0]     err_cnt
);

`ifdef ADDR8S_TR_VOTE_EN
    typedef enum logic [2:0] {IDLE, PASS1, PASS2, PASS3, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, PASS1, PASS2, DONE} state_t;
`endif

    localparam logic [3:0] SETTLE = SETTLE_CYCLES[3:0];

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [8:0] r1;
`ifdef ADDR8S_TR_VOTE_EN
    logic [8:0] r2;
`endif
    logic [8:0] sum_q;
    logic       err_q;
    logic       expire;
    logic       mismatch;
    logic       err_inc;

    assign expire   = (cnt == 4'd1);
    assign mismatch = (add_sum != r1);
    assign err_inc  = (state == PASS2) && expire && mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid)
                    state_next = PASS1;
            end
            PASS1: begin
                if (expire)
                    state_next = PASS2;
            end
            PASS2: begin
                if (expire) begin
`ifdef ADDR8S_TR_VOTE_EN
                    state_next = mismatch ? PASS3 : DONE;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef ADDR8S_TR_VOTE_EN
            PASS3: begin
                if (expire)
                    state_next = DONE;
            end
`endif
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands stay on the adder after a result is delivered; only a new accept replaces them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a <= 8'h00;
            add_b <= 8'h00;
            op_a  <= 8'h00;
            op_b  <= 8'h00;
            cnt   <= 4'd0;
            r1    <= 9'h000;
`ifdef ADDR8S_TR_VOTE_EN
            r2    <= 9'h000;
`endif
            sum_q <= 9'h000;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_a  <= bus.in_a;
                        op_b  <= bus.in_b;
                        add_a <= bus.in_a;
                        add_b <= bus.in_b;
                        cnt   <= SETTLE;
                    end
                end
                PASS1: begin
                    if (expire) begin
                        r1    <= add_sum;
                        add_a <= op_b;
                        add_b <= op_a;
                        cnt   <= SETTLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                PASS2: begin
                    if (expire) begin
                        sum_q <= r1;
                        err_q <= mismatch;
`ifdef ADDR8S_TR_VOTE_EN
                        if (mismatch) begin
                            r2    <= add_sum;
                            add_a <= op_a;
                            add_b <= op_b;
                            cnt   <= SETTLE;
                        end
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
`ifdef ADDR8S_TR_VOTE_EN
                PASS3: begin
                    // r1 wins ties and three-way disagreement; r2 only when the third pass backs it.
                    if (expire)
                        sum_q <= (add_sum != r1 && add_sum == r2) ? r2 : r1;
                    else
                        cnt <= cnt - 4'd1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.out_sum = sum_q;
    assign bus.out_err = err_q;

    // A clear coinciding with a new mismatch keeps that mismatch, leaving the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (err_clr)
            err_cnt <= err_inc ? ERR_W'(1) : '0;
        else if (err_inc && err_cnt != '1)
            err_cnt <= err_cnt + ERR_W'(1);
    end

endmodule

// File: tb/tb_addr8s_tr_checker.sv
// Directed bench for addr8s_tr_checker: a default instance and a fast one (SETTLE_CYCLES=1, ERR_W=2),
// each driving a behavioural adder that can corrupt the swapped 5+3 pass.
module tb_addr8s_tr_checker;

`ifdef ADDR8S_TR_VOTE_EN
    localparam int MIS_LAT0 = 6;
    localparam int MIS_LAT1 = 3;
`else
    localparam int MIS_LAT0 = 4;
    localparam int MIS_LAT1 = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a0, b0, a1, b1;
    logic [8:0] s0, s1;
    logic       clr0, clr1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    logic       corrupt0;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    addr8s_tr_checker_if if0 ();
    addr8s_tr_checker_if if1 ();

    assign s0 = ({a0[7], a0} + {b0[7], b0}) ^ ((corrupt0 && a0 == 8'h05 && b0 == 8'h03) ? 9'h001 : 9'h000);
    assign s1 = ({a1[7], a1} + {b1[7], b1}) ^ ((a1 == 8'h05 && b1 == 8'h03) ? 9'h001 : 9'h000);

    addr8s_tr_checker u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0),
        .add_a(a0), .add_b(b0), .add_sum(s0),
        .err_clr(clr0), .err_cnt(cnt0)
    );

    addr8s_tr_checker #(.SETTLE_CYCLES(1), .ERR_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1),
        .add_a(a1), .add_b(b1), .add_sum(s1),
        .err_clr(clr1), .err_cnt(cnt1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offers a pair to u0 and returns the number of edges from the accept edge to out_valid.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, output int lat);
        int guard = 0;
        if0.in_valid = 1'b1;
        if0.in_a     = a;
        if0.in_b     = b;
        while (!if0.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        lat = 0;
        while (!if0.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain0();
        if0.out_ready = 1'b1;
        @(posedge clk); #1;
        if0.out_ready = 1'b0;
    endtask

    // Same for u1 (out_ready held high); clr raises err_clr for the PASS2-expiry edge.
    task automatic applyStimulusFast(input logic [7:0] a, input logic [7:0] b, input logic clr, output int lat);
        int guard = 0;
        if1.in_valid = 1'b1;
        if1.in_a     = a;
        if1.in_b     = b;
        while (!if1.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        if1.in_valid = 1'b0;
        lat = 0;
        while (!if1.out_valid && lat < 40) begin
            clr1 = (lat == 1) ? clr : 1'b0;
            @(posedge clk); #1;
            clr1 = 1'b0;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int seen;
        logic [1:0] exp_cnt;
        rst_n         = 1'b0;
        corrupt0      = 1'b0;
        clr0          = 1'b0;
        clr1          = 1'b0;
        if0.in_valid  = 1'b0; if0.in_a = 8'h00; if0.in_b = 8'h00; if0.out_ready = 1'b0;
        if1.in_valid  = 1'b0; if1.in_a = 8'h00; if1.in_b = 8'h00; if1.out_ready = 1'b1;
        #1;
        checkOutput("rst_out_valid", 32'(if0.out_valid), 32'h0);
        checkOutput("rst_add_a", 32'(a0), 32'h0);
        checkOutput("rst_err_cnt", 32'(cnt0), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_in_ready", 32'(if0.in_ready), 32'h1);

        applyStimulus(8'h7F, 8'h01, lat);
        checkOutput("7f_lat", 32'(lat), 32'd4);
        checkOutput("7f_sum", 32'(if0.out_sum), 32'h080);
        checkOutput("7f_err", 32'(if0.out_err), 32'h0);
        checkOutput("7f_swap_a", 32'(a0), 32'h01);
        checkOutput("7f_swap_b", 32'(b0), 32'h7F);
        drain0();
        checkOutput("7f_valid_drop", 32'(if0.out_valid), 32'h0);

        applyStimulus(8'h80, 8'h80, lat);
        checkOutput("80_sum", 32'(if0.out_sum), 32'h100);
        drain0();
        applyStimulus(8'hFF, 8'h01, lat);
        checkOutput("ff_sum", 32'(if0.out_sum), 32'h000);
        drain0();

        corrupt0 = 1'b1;
        applyStimulus(8'h03, 8'h05, lat);
        checkOutput("mis_lat", 32'(lat), 32'(MIS_LAT0));
        checkOutput("mis_sum", 32'(if0.out_sum), 32'h008);
        checkOutput("mis_err", 32'(if0.out_err), 32'h1);
        checkOutput("mis_cnt", 32'(cnt0), 32'h1);
        drain0();
        corrupt0 = 1'b0;

        // Backpressure: a new pair waits while the held result sits in DONE.
        applyStimulus(8'h10, 8'h20, lat);
        if0.in_valid = 1'b1; if0.in_a = 8'h11; if0.in_b = 8'h22;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("bp_sum", 32'(if0.out_sum), 32'h030);
            checkOutput("bp_ready", 32'(if0.in_ready), 32'h0);
        end
        if0.out_ready = 1'b1;
        @(posedge clk); #1;
        if0.out_ready = 1'b0;
        checkOutput("bp_ready_back", 32'(if0.in_ready), 32'h1);
        checkOutput("bp_ops_held", 32'(a0), 32'h20);
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        checkOutput("bp_accept_a", 32'(a0), 32'h11);
        checkOutput("bp_accept_b", 32'(b0), 32'h22);
        lat = 0;
        while (!if0.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("bp2_lat", 32'(lat), 32'd4);
        checkOutput("bp2_sum", 32'(if0.out_sum), 32'h033);

        // Reset while a result is held, then reset while a pair is in flight.
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst2_valid", 32'(if0.out_valid), 32'h0);
        checkOutput("rst2_add_a", 32'(a0), 32'h0);
        checkOutput("rst2_add_b", 32'(b0), 32'h0);
        checkOutput("rst2_sum", 32'(if0.out_sum), 32'h0);
        checkOutput("rst2_cnt", 32'(cnt0), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst2_ready", 32'(if0.in_ready), 32'h1);
        if0.in_valid = 1'b1; if0.in_a = 8'h01; if0.in_b = 8'h01;
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (if0.out_valid) seen++;
        end
        checkOutput("abort_no_valid", 32'(seen), 32'd0);
        checkOutput("abort_ready", 32'(if0.in_ready), 32'h1);

        // Fast instance: back-to-back good pairs.
        applyStimulusFast(8'h10, 8'h01, 1'b0, lat);
        checkOutput("f1_lat", 32'(lat), 32'd2);
        checkOutput("f1_sum", 32'(if1.out_sum), 32'h011);
        applyStimulusFast(8'h80, 8'h7F, 1'b0, lat);
        checkOutput("f2_lat", 32'(lat), 32'd2);
        checkOutput("f2_sum", 32'(if1.out_sum), 32'h1FF);
        applyStimulusFast(8'h40, 8'h40, 1'b0, lat);
        checkOutput("f3_sum", 32'(if1.out_sum), 32'h080);
        checkOutput("f3_err", 32'(if1.out_err), 32'h0);

        // Saturation of the 2-bit mismatch counter.
        exp_cnt = 2'd0;
        for (int i = 0; i < 4; i++) begin
            applyStimulusFast(8'h03, 8'h05, 1'b0, lat);
            if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
            checkOutput("sat_lat", 32'(lat), 32'(MIS_LAT1));
            checkOutput("sat_sum", 32'(if1.out_sum), 32'h008);
            checkOutput("sat_cnt", 32'(cnt1), 32'(exp_cnt));
        end
        applyStimulusFast(8'h03, 8'h05, 1'b1, lat);
        checkOutput("clr_inc_cnt", 32'(cnt1), 32'h1);
        @(posedge clk); #1;
        clr1 = 1'b1;
        @(posedge clk); #1;
        clr1 = 1'b0;
        checkOutput("clr_alone_cnt", 32'(cnt1), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
